parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 SHALL have parameter: DEB_CYCLES, 4, consecutive stable cycles before a debounced beam changes (range 1..255).
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 1000, maximum cycles allowed in any non-IDLE state (range 1..65535).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: beamA  input  1  outer lane beam, asynchronous raw input, 1 = blocked.
REQ-006 SHALL have port: beamB  input  1  inner lane beam, asynchronous raw input, 1 = blocked.
REQ-007 SHALL have port: Full  input  1  lot-full flag from the parking counter.
REQ-008 SHALL have port: carIn  output  1  one-cycle pulse on each completed entry.
REQ-009 SHALL have port: carOut  output  1  one-cycle pulse on each completed exit.
REQ-010 SHALL have port: gateOpen  output  1  barrier command, 1 = raised.
REQ-011 SHALL have port: denied  output  1  one-cycle pulse when an entry is refused because the lot is full.
REQ-012 SHALL have port: fault  output  1  one-cycle pulse on a timeout abort.

Function
REQ-013 SHALL pass beamA and beamB each through a 2-flop synchronizer and then an independent debouncer.
REQ-014 SHALL change a debounced beam only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any glitch restarts the count.
REQ-015 SHALL implement FSM states IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, DENY, evaluated on the debounced pair (a,b).
REQ-016 IDLE transitions SHALL be: (1,0) with Full=0 -> IN_A; (1,0) with Full=1 -> DENY plus a denied pulse; (0,1) -> OUT_B; (1,1) and (0,0) -> stay in IDLE.
REQ-017 Entry transitions SHALL be: IN_A: (1,1)->IN_AB, else not (1,0)->IDLE; IN_AB: (0,1)->IN_B, (1,0)->IN_A, (0,0)->IDLE; IN_B: (0,0)->IDLE plus a carIn pulse, (1,1)->IN_AB, (1,0)->IDLE.
REQ-018 Exit transitions SHALL mirror REQ-017 with a and b swapped (OUT_B, OUT_BA, OUT_A); OUT_A to (0,0) SHALL pulse carOut.
REQ-019 DENY SHALL remain until (0,0) and then return to IDLE, with no carIn issued.
REQ-020 SHALL register carIn, carOut, denied and fault and assert them exactly one cycle after the triggering state transition, for exactly one cycle.
REQ-021 SHALL drive gateOpen high in every IN_* and OUT_* state and low in IDLE and DENY, as a registered output.
REQ-022 A Full change after leaving IDLE SHALL NOT abort an entry in progress.
REQ-023 An abort (reversal or an invalid pattern) SHALL return the FSM to IDLE with no pulse.
REQ-024 At most one of carIn, carOut, denied and fault SHALL be high in any cycle.

Reset
REQ-025 While reset=0, all outputs SHALL be 0, the FSM SHALL be IDLE, the debounced beams, synchronizers and counters SHALL be 0.
REQ-026 Reset asserted mid-sequence SHALL discard the sequence; after release, a beam already blocked SHALL be treated as a new debounced event.

Configuration
REQ-027 With GATE_TIMEOUT_EN defined, a counter SHALL clear on every state change; after TIMEOUT_CYCLES cycles in a non-IDLE state, the FSM SHALL go to IDLE and pulse fault.
REQ-028 Without GATE_TIMEOUT_EN, the timeout counter SHALL be absent, non-IDLE states SHALL wait indefinitely, and fault SHALL be tied to 0.

Verification
REQ-029 Full=0, A; A+B; B; clear, each held 10 cycles -> exactly one carIn pulse, gateOpen high from the IN_A entry until IDLE, carOut=0.
REQ-030 B; B+A; A; clear, each held 10 cycles -> exactly one carOut pulse, no carIn.
REQ-031 Full=1, A held 10 cycles then cleared -> one denied pulse, gateOpen stays 0, no carIn.
REQ-032 beamA glitch of 3 cycles with DEB_CYCLES=4 -> no state change and no outputs; a 4-cycle hold -> enters IN_A.
REQ-033 A; A+B; A; clear (reversal) -> returns to IDLE with no pulses.
REQ-034 With GATE_TIMEOUT_EN and TIMEOUT_CYCLES=50, A held 60 cycles -> fault pulse and return to IDLE; reset=0 during IN_AB -> all outputs 0 immediately.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: two-beam lane direction detector that drives a parking lot barrier.
// Optional feature: define GATE_TIMEOUT_EN to abort any sequence stalled for TIMEOUT_CYCLES.
module parking_gate_ctrl #(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic beamA,
    input  logic beamB,
    input  logic Full,
    output logic carIn,
    output logic carOut,
    output logic gateOpen,
    output logic denied,
    output logic fault
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IN_A   = 3'd1,
        IN_AB  = 3'd2,
        IN_B   = 3'd3,
        OUT_B  = 3'd4,
        OUT_BA = 3'd5,
        OUT_A  = 3'd6,
        DENY   = 3'd7
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
        $error("parking_gate_ctrl: DEB_CYCLES out of range 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("parking_gate_ctrl: TIMEOUT_CYCLES out of range 1..65535");
    end

    logic [1:0] sync_q1;
    logic [1:0] sync_q2;
    logic [1:0] deb;
    logic [7:0] deb_cnt [2];

    state_t state;
    state_t state_next;
    logic   entry_done;
    logic   exit_done;
    logic   deny_hit;
    logic   timeout_hit;
    logic   fault_hit;

    logic   gate_next;
    logic   car_in_next;
    logic   car_out_next;
    logic   denied_next;
    logic   fault_next;

    logic   a;
    logic   b;

    // Index 0 carries the outer beam, index 1 the inner beam.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {beamB, beamA};
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb        <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync_q2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign a = deb[0];
    assign b = deb[1];

`ifdef GATE_TIMEOUT_EN
    localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr <= '0;
        end else if (state == IDLE || state_next != state) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 16'd1;
        end
    end

    assign timeout_hit = (state != IDLE) && (tmr == TMR_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Entry walks A -> AB -> B -> clear; exit is the mirror image. Anything else aborts silently.
    always_comb begin
        state_next = state;
        entry_done = 1'b0;
        exit_done  = 1'b0;
        deny_hit   = 1'b0;
        fault_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (a && !b) begin
                    if (Full) begin
                        state_next = DENY;
                        deny_hit   = 1'b1;
                    end else begin
                        state_next = IN_A;
                    end
                end else if (!a && b) begin
                    state_next = OUT_B;
                end
            end
            IN_A: begin
                if (a && b)       state_next = IN_AB;
                else if (!a || b) state_next = IDLE;
            end
            IN_AB: begin
                if (!a && b)       state_next = IN_B;
                else if (a && !b)  state_next = IN_A;
                else if (!a && !b) state_next = IDLE;
            end
            IN_B: begin
                if (!a && !b) begin
                    state_next = IDLE;
                    entry_done = 1'b1;
                end else if (a && b) begin
                    state_next = IN_AB;
                end else if (a && !b) begin
                    state_next = IDLE;
                end
            end
            OUT_B: begin
                if (a && b)       state_next = OUT_BA;
                else if (a || !b) state_next = IDLE;
            end
            OUT_BA: begin
                if (a && !b)       state_next = OUT_A;
                else if (!a && b)  state_next = OUT_B;
                else if (!a && !b) state_next = IDLE;
            end
            OUT_A: begin
                if (!a && !b) begin
                    state_next = IDLE;
                    exit_done  = 1'b1;
                end else if (a && b) begin
                    state_next = OUT_BA;
                end else if (!a && b) begin
                    state_next = IDLE;
                end
            end
            DENY: begin
                if (!a && !b) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (timeout_hit) begin
            state_next = IDLE;
            entry_done = 1'b0;
            exit_done  = 1'b0;
            deny_hit   = 1'b0;
            fault_hit  = 1'b1;
        end
    end

    always_comb begin
        gate_next    = 1'b0;
        car_in_next  = entry_done;
        car_out_next = exit_done;
        denied_next  = deny_hit;
        fault_next   = fault_hit;
        if (state_next inside {IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A}) begin
            gate_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gateOpen <= 1'b0;
            carIn    <= 1'b0;
            carOut   <= 1'b0;
            denied   <= 1'b0;
        end else begin
            gateOpen <= gate_next;
            carIn    <= car_in_next;
            carOut   <= car_out_next;
            denied   <= denied_next;
        end
    end

`ifdef GATE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_next;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed self-checking bench for parking_gate_ctrl (DEB_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_parking_gate_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic beamA = 1'b0;
    logic beamB = 1'b0;
    logic Full  = 1'b0;
    logic carIn;
    logic carOut;
    logic gateOpen;
    logic denied;
    logic fault;

    int total = 0;
    int bad   = 0;

    int n_in;
    int n_out;
    int n_deny;
    int n_fault;
    int n_gate;
    int n_fault_gate;
    int n_multi = 0;

    always #5 clk = ~clk;

    parking_gate_ctrl #(
        .DEB_CYCLES    (4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .beamA   (beamA),
        .beamB   (beamB),
        .Full    (Full),
        .carIn   (carIn),
        .carOut  (carOut),
        .gateOpen(gateOpen),
        .denied  (denied),
        .fault   (fault)
    );

    task automatic clear_counts();
        n_in         = 0;
        n_out        = 0;
        n_deny       = 0;
        n_fault      = 0;
        n_gate       = 0;
        n_fault_gate = 0;
    endtask

    // Drive a beam pattern for n cycles, tallying outputs sampled on each falling edge.
    task automatic hold(input logic a, input logic b, input int n);
        beamA = a;
        beamB = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_in    += int'(carIn);
            n_out   += int'(carOut);
            n_deny  += int'(denied);
            n_fault += int'(fault);
            n_gate  += int'(gateOpen);
            if (fault && gateOpen) n_fault_gate++;
            if (int'(carIn) + int'(carOut) + int'(denied) + int'(fault) > 1) n_multi++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({carIn, carOut, gateOpen, denied, fault} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b want 00000", {carIn, carOut, gateOpen, denied, fault});
        end
        reset = 1'b1;
        clear_counts();
        hold(1'b0, 1'b0, 10);
        total++;
        if (n_gate !== 0 || n_in + n_out + n_deny + n_fault !== 0) begin
            bad++;
            $display("[TB] FAIL reset_idle_quiet: gate=%0d pulses=%0d want 0 0", n_gate, n_in + n_out + n_deny + n_fault);
        end
    endtask

    task automatic test_entry();
        Full = 1'b0;
        clear_counts();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);
        hold(1'b0, 1'b0, 5);
        total++;
        if (n_in !== 1) begin
            bad++;
            $display("[TB] FAIL entry_carIn: got %0d pulses want 1", n_in);
        end
        total++;
        if (n_out !== 0) begin
            bad++;
            $display("[TB] FAIL entry_carOut: got %0d pulses want 0", n_out);
        end
        total++;
        if (n_gate !== 30) begin
            bad++;
            $display("[TB] FAIL entry_gate_cycles: got %0d want 30", n_gate);
        end
        total++;
        if (gateOpen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL entry_gate_closed: got %b want 0", gateOpen);
        end
    endtask

    task automatic test_exit();
        Full = 1'b0;
        clear_counts();
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 15);
        total++;
        if (n_out !== 1) begin
            bad++;
            $display("[TB] FAIL exit_carOut: got %0d pulses want 1", n_out);
        end
        total++;
        if (n_in !== 0) begin
            bad++;
            $display("[TB] FAIL exit_carIn: got %0d pulses want 0", n_in);
        end
        total++;
        if (n_gate !== 30) begin
            bad++;
            $display("[TB] FAIL exit_gate_cycles: got %0d want 30", n_gate);
        end
    endtask

    task automatic test_deny();
        Full = 1'b1;
        clear_counts();
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 15);
        Full = 1'b0;
        total++;
        if (n_deny !== 1) begin
            bad++;
            $display("[TB] FAIL deny_pulse: got %0d pulses want 1", n_deny);
        end
        total++;
        if (n_gate !== 0) begin
            bad++;
            $display("[TB] FAIL deny_gate: got %0d open cycles want 0", n_gate);
        end
        total++;
        if (n_in !== 0) begin
            bad++;
            $display("[TB] FAIL deny_carIn: got %0d pulses want 0", n_in);
        end
    endtask

    task automatic test_debounce();
        clear_counts();
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 12);
        total++;
        if (n_gate !== 0 || n_in + n_out + n_deny + n_fault !== 0) begin
            bad++;
            $display("[TB] FAIL glitch_ignored: gate=%0d pulses=%0d want 0 0", n_gate, n_in + n_out + n_deny + n_fault);
        end
        clear_counts();
        hold(1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 16);
        total++;
        if (n_gate !== 4) begin
            bad++;
            $display("[TB] FAIL hold4_enters_in_a: got %0d open cycles want 4", n_gate);
        end
        total++;
        if (n_in + n_out + n_deny + n_fault !== 0) begin
            bad++;
            $display("[TB] FAIL hold4_no_pulse: got %0d pulses want 0", n_in + n_out + n_deny + n_fault);
        end
    endtask

    task automatic test_reversal();
        clear_counts();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 15);
        total++;
        if (n_in + n_out + n_deny + n_fault !== 0) begin
            bad++;
            $display("[TB] FAIL reversal_no_pulse: got %0d pulses want 0", n_in + n_out + n_deny + n_fault);
        end
        total++;
        if (n_gate !== 30 || gateOpen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reversal_gate: got %0d cycles final %b want 30 final 0", n_gate, gateOpen);
        end
    endtask

    task automatic test_full_change();
        Full = 1'b0;
        clear_counts();
        hold(1'b1, 1'b0, 10);
        Full = 1'b1;
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 15);
        Full = 1'b0;
        total++;
        if (n_in !== 1 || n_deny !== 0) begin
            bad++;
            $display("[TB] FAIL full_midway: carIn=%0d denied=%0d want 1 0", n_in, n_deny);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        total++;
        if (gateOpen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_in_ab_gate: got %b want 1", gateOpen);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({carIn, carOut, gateOpen, denied, fault} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_async: got %b want 00000", {carIn, carOut, gateOpen, denied, fault});
        end
        hold(1'b1, 1'b0, 3);
        reset = 1'b1;
        clear_counts();
        hold(1'b1, 1'b0, 10);
        total++;
        if (n_gate !== 4) begin
            bad++;
            $display("[TB] FAIL mid_reset_new_event: got %0d open cycles want 4", n_gate);
        end
        hold(1'b0, 1'b0, 15);
        total++;
        if (n_in + n_out + n_deny + n_fault !== 0 || gateOpen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_discard: pulses=%0d gate=%b want 0 0", n_in + n_out + n_deny + n_fault, gateOpen);
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        hold(1'b1, 1'b0, 60);
`ifdef GATE_TIMEOUT_EN
        total++;
        if (n_fault !== 1) begin
            bad++;
            $display("[TB] FAIL timeout_fault: got %0d pulses want 1", n_fault);
        end
        total++;
        if (n_fault_gate !== 0) begin
            bad++;
            $display("[TB] FAIL timeout_gate_drop: got %0d fault cycles with gate open want 0", n_fault_gate);
        end
        total++;
        if (n_gate !== 53) begin
            bad++;
            $display("[TB] FAIL timeout_gate_cycles: got %0d want 53", n_gate);
        end
`else
        total++;
        if (n_fault !== 0) begin
            bad++;
            $display("[TB] FAIL no_timeout_fault: got %0d pulses want 0", n_fault);
        end
        total++;
        if (n_gate !== 54 || gateOpen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL no_timeout_wait: got %0d cycles final %b want 54 final 1", n_gate, gateOpen);
        end
`endif
        hold(1'b0, 1'b0, 12);
        total++;
        if (gateOpen !== 1'b0 || n_in + n_out + n_deny !== 0) begin
            bad++;
            $display("[TB] FAIL timeout_clear: gate=%b pulses=%0d want 0 0", gateOpen, n_in + n_out + n_deny);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 15);
        total++;
        if (n_in !== 1 || n_out !== 1) begin
            bad++;
            $display("[TB] FAIL back_to_back: carIn=%0d carOut=%0d want 1 1", n_in, n_out);
        end
        total++;
        if (n_multi !== 0) begin
            bad++;
            $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles want 0", n_multi);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_entry();
        test_exit();
        test_deny();
        test_debounce();
        test_reversal();
        test_full_change();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
